// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a one-word skid slot.
// out_data comes straight from the main register, and in_ready/out_valid/count
// are decoded from the state register alone. That keeps any combinational path
// from out_ready to in_ready out of this stage.
//
//   state | meaning
//   ------+-------------------------------------------------
//   EMPTY | nothing held; out_valid=0, in_ready=1
//   ONE   | main holds the oldest word; skid unused
//   TWO   | main holds the oldest word, skid the next; in_ready=0
module pipe_skid_stage #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    // Each state's encoding is also its occupancy, so count is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [width-1:0] main_q;
    logic [width-1:0] skid_q;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign count     = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and load-enable decode.
    // A flush empties the stage and drops any word accepted in the same cycle.
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Data registers. They are cleared on reset, and a flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage. It applies a vector table for the directed cases and
// then a long random run. A FIFO model, sb, holds the words the stage should
// contain. Each cycle the bench compares the stage's flags and head word with
// the model before the edge. Words enter the model on acceptance and leave it
// on emission.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb[$];

    typedef struct {
        logic        r;
        logic        f;
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic [1:0]  cnt;
        logic        ir;
        logic        ov;
        logic        chkd;
        logic [15:0] od;
    } vec_t;

    vec_t vq[$];

    pipe_skid_stage #(.width(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, checks the stage against the model, clocks it,
    // and then updates the model.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [15:0] d, input logic ordy);
        logic exp_ir;
        logic exp_ov;
        logic ofire;
        logic ifire;
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        exp_ir = (sb.size() < 2);
        exp_ov = (sb.size() > 0);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("count", 32'(count), 32'(sb.size()));
        if (exp_ov) chk("out_data_head", 32'(out_data), 32'(sb[0]));
        ofire = exp_ov && ordy;
        ifire = iv && exp_ir;
        @(posedge clk);
        #1;
        if (r || f) begin
            sb.delete();
        end else begin
            if (ofire) void'(sb.pop_front());
            if (ifire) sb.push_back(d);
        end
        if (r) chk("out_data_after_reset", 32'(out_data), 32'h0);
    endtask

    initial begin
        logic [15:0] pend;
        logic        pend_v;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        //                r  f  iv  d        ordy cnt  ir ov chkd od
        // reset with a word on offer: the word must not be captured
        vq.push_back('{1, 0, 1, 16'hDEAD, 0, 2'd0, 1, 0, 1, 16'h0000});
        vq.push_back('{0, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 1, 16'h0000});
        // streaming with out_ready high
        vq.push_back('{0, 0, 1, 16'h1111, 1, 2'd1, 1, 1, 1, 16'h1111});
        vq.push_back('{0, 0, 1, 16'h2222, 1, 2'd1, 1, 1, 1, 16'h2222});
        vq.push_back('{0, 0, 1, 16'h3333, 1, 2'd1, 1, 1, 1, 16'h3333});
        vq.push_back('{0, 0, 0, 16'h0000, 1, 2'd0, 1, 0, 0, 16'h0000});
        // backpressure: the stage fills, then CCCC is held by the producer
        vq.push_back('{0, 0, 1, 16'hAAAA, 0, 2'd1, 1, 1, 1, 16'hAAAA});
        vq.push_back('{0, 0, 1, 16'hBBBB, 0, 2'd2, 0, 1, 1, 16'hAAAA});
        vq.push_back('{0, 0, 1, 16'hCCCC, 0, 2'd2, 0, 1, 1, 16'hAAAA});
        vq.push_back('{0, 0, 1, 16'hCCCC, 0, 2'd2, 0, 1, 1, 16'hAAAA});
        vq.push_back('{0, 0, 1, 16'hCCCC, 1, 2'd1, 1, 1, 1, 16'hBBBB});
        vq.push_back('{0, 0, 1, 16'hCCCC, 1, 2'd1, 1, 1, 1, 16'hCCCC});
        vq.push_back('{0, 0, 0, 16'h0000, 1, 2'd0, 1, 0, 0, 16'h0000});
        // flush while full, with a word offered in the same cycle
        vq.push_back('{0, 0, 1, 16'h1234, 0, 2'd1, 1, 1, 1, 16'h1234});
        vq.push_back('{0, 0, 1, 16'h5678, 0, 2'd2, 0, 1, 1, 16'h1234});
        vq.push_back('{0, 1, 1, 16'h5A5A, 0, 2'd0, 1, 0, 0, 16'h0000});
        vq.push_back('{0, 0, 0, 16'h0000, 1, 2'd0, 1, 0, 0, 16'h0000});
        // reset while full, then normal use afterwards
        vq.push_back('{0, 0, 1, 16'h4444, 0, 2'd1, 1, 1, 1, 16'h4444});
        vq.push_back('{0, 0, 1, 16'h5555, 0, 2'd2, 0, 1, 1, 16'h4444});
        vq.push_back('{1, 0, 0, 16'h0000, 0, 2'd0, 1, 0, 1, 16'h0000});
        vq.push_back('{0, 0, 1, 16'h0F0F, 0, 2'd1, 1, 1, 1, 16'h0F0F});
        vq.push_back('{0, 0, 0, 16'h0000, 1, 2'd0, 1, 0, 0, 16'h0000});

        foreach (vq[i]) begin
            cycle(vq[i].r, vq[i].f, vq[i].iv, vq[i].d, vq[i].ordy);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vq[i].cnt));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vq[i].ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vq[i].ov));
            if (vq[i].chkd) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vq[i].od));
        end

        // Random run. The producer keeps its word until that word is accepted.
        pend_v = 1'b0;
        pend   = '0;
        for (int n = 0; n < 10000; n++) begin
            logic iv;
            logic ordy;
            logic acc;
            if (!pend_v) begin
                pend_v = ($urandom_range(0, 2) != 0);
                pend   = 16'($urandom);
            end
            iv   = pend_v;
            ordy = ($urandom_range(0, 2) != 0);
            acc  = iv && in_ready;
            cycle(1'b0, 1'b0, iv, pend, ordy);
            if (acc) pend_v = 1'b0;
        end

        for (int n = 0; n < 3; n++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("drained_count", 32'(count), 32'h0);
        chk("drained_out_valid", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
